// File: rtl/mips_cpu_bus_arbiter.sv
// Arbiter that merges the CPU fetch and data ports onto one Avalon-style bus.
// Data has priority over fetch. Bus outputs are registered, and each port gets a one-cycle valid pulse.
module mips_cpu_bus_arbiter #(
  parameter logic [31:0] RESET_ADDR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_byteenable,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
  state_t state;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = (dm_read | dm_write) & ~dm_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      address    <= RESET_ADDR;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0;
      byteenable <= 4'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A request seen together with its own valid pulse is already served.
          if ((dm_read | dm_write) && !dm_valid) begin
            state      <= DATA;
            address    <= dm_addr;
            writedata  <= dm_wdata;
            byteenable <= dm_byteenable;
            write      <= dm_write;
            read       <= ~dm_write;
          end else if (if_req && !if_valid) begin
            state      <= INSTR;
            address    <= if_addr;
            writedata  <= 32'h0;
            byteenable <= 4'hF;
            write      <= 1'b0;
            read       <= 1'b1;
          end
        end
        DATA, INSTR: begin
          if (!waitrequest) begin
            if (state == DATA) begin
              if (read) dm_rdata <= readdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= readdata;
              if_valid <= 1'b1;
            end
            state      <= IDLE;
            address    <= RESET_ADDR;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Merges the pipelined CPU's instruction-fetch port and data-memory port onto the single Avalon-style bus that `mips_cpu_bus_pipeline` exposes to memory (`address`, `read`, `write`, `writedata`, `byteenable`, `readdata`, `waitrequest`). It sits directly downstream of the IF and MEM stages and directly upstream of the bus/memory. It serialises accesses, holds bus signals stable under `waitrequest`, returns read data with a one-cycle valid pulse, and generates per-port stall signals for the hazard unit.

## Interface
Parameters:
- `RESET_ADDR`, 32'hBFC00000, value driven on `address` while idle/reset (no strobe asserted).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `if_req`  in  1  instruction fetch request; held high until `if_valid`.
- `if_addr`  in  32  fetch address (word aligned).
- `if_rdata`  out  32  fetched instruction; valid while `if_valid`.
- `if_valid`  out  1  one-cycle completion pulse for fetch.
- `if_stall`  out  1  `if_req & ~if_valid`.
- `dm_read`, `dm_write`  in  1 each  data request; held until `dm_valid`.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  store data.
- `dm_byteenable`  in  4  lane enables for load/store.
- `dm_rdata`  out  32  load data; valid while `dm_valid`.
- `dm_valid`  out  1  one-cycle completion pulse for data.
- `dm_stall`  out  1  `(dm_read|dm_write) & ~dm_valid`.
- `address`  out  32  bus address.
- `read`, `write`  out  1 each  bus strobes; never both high.
- `writedata`  out  32  bus write data.
- `byteenable`  out  4  bus lane enables.
- `readdata`  in  32  bus read data, valid in the cycle `waitrequest` is low with `read` high.
- `waitrequest`  in  1  bus stall.

## Operation
- States: IDLE, DATA, INSTR.
- IDLE: bus strobes low, `address`=`RESET_ADDR`, `byteenable`=0. At a rising edge:
  - data request pending and `dm_valid`=0 → latch `dm_addr/dm_wdata/dm_byteenable`/direction, go DATA.
  - else `if_req` and `if_valid`=0 → latch `if_addr`, go INSTR.
  - A request high in the same cycle as its own valid pulse is treated as acknowledged and never relaunched.
- Priority: data over instruction (older instruction in flight); no starvation, since MEM drops its request after `dm_valid`.
- `dm_read` and `dm_write` both high: treated as write.
- DATA: drive latched address, `byteenable`, `writedata`; `read`=~dir, `write`=dir. INSTR: latched address, `read`=1, `byteenable`=4'b1111, `writedata`=0.
- Completion: rising edge with strobe high and `waitrequest`=0. Reads capture `readdata` into the port's rdata register; writes leave `dm_rdata` unchanged. Set the port valid for the next cycle; return to IDLE.
- Bus outputs come only from latched registers; input changes during DATA/INSTR are ignored.
- `if_rdata`/`dm_rdata` hold the last captured value between accesses.

## Timing
- Reset (async): state=IDLE; `read`=`write`=0, `address`=`RESET_ADDR`, `byteenable`=0, `writedata`=0, `if_rdata`=`dm_rdata`=0, `if_valid`=`dm_valid`=0. Effective immediately, including mid-transaction with `waitrequest` high; the in-flight access is dropped.
- Zero-wait access: request in cycle 0 → strobe in cycle 1 → valid in cycle 2. Each `waitrequest`-high cycle adds one cycle.
- Throughput: one access per 3 cycles per port when memory is zero-wait. A pending fetch launches in the valid cycle of a data access (IDLE with `dm_valid`=1), so alternating accesses need no extra idle cycle.
- Stalls are combinational from requests and valid; no added latency.
- Valid pulses are exactly one cycle; never both high together.

## Test plan
- Reset: assert `reset` mid-DATA read with `waitrequest`=1 → same-cycle `read`=0, `address`=32'hBFC00000, valids 0. After release, IDLE.
- Fetch, zero wait: `if_req`=1, `if_addr`=32'hBFC00000, mem word 32'h24020005 → `read`=1 cycle 1, `byteenable`=4'hF, `if_valid`=1 and `if_rdata`=32'h24020005 in cycle 2, `if_stall` low in cycle 2.
- Waitrequest: load at 32'h00001000 with `waitrequest` high 3 cycles → `address`/`read`/`byteenable` constant 4 cycles, `dm_valid` in cycle 5 with correct data.
- Contention: `if_req` and `dm_read` both raised in cycle 0 → data access first (valid cycle 2). Fetch strobe in cycle 3, `if_valid` in cycle 4.
- Store: `dm_write`, addr 32'h00002000, `dm_wdata`=32'hDEADBEEF, `dm_byteenable`=4'b0011 → `write`=1, `read`=0, `byteenable`=4'b0011, `writedata`=32'hDEADBEEF. `dm_valid` pulse; `dm_rdata` unchanged; memory readback 32'h0000BEEF over zeroed word.
- No relaunch: requester holds `if_req` through the `if_valid` cycle then drops → exactly one bus read issued.
